// File: rtl/audio_record_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// audio_record_ctrl_pkg
// Shared constants and types for the audio capture path. The default packet
// count and word width also size the playback side, so both paths agree on
// how many packets a recording holds.
// Contents:
//   AUD_CLK_DIV    clk cycles per micClk half-period
//   AUD_WORD_W     bits per packet stored in audio memory
//   AUD_ADDR_W     audio memory address width
//   AUD_MEM_DEPTH  packets per recording
//   rec_state_e    capture FSM state encoding
// ----------------------------------------------------------------------------
package audio_record_ctrl_pkg;

    localparam int AUD_CLK_DIV   = 50;   // 100 MHz clk -> 1 MHz micClk
    localparam int AUD_WORD_W    = 32;
    localparam int AUD_ADDR_W    = 10;
    localparam int AUD_MEM_DEPTH = 937;

    typedef enum logic [1:0] {
        REC_IDLE   = 2'd0,
        REC_PREREC = 2'd1,   // settling word, captured but never written
        REC_RECORD = 2'd2,
        REC_DONE   = 2'd3
    } rec_state_e;

endpackage

// File: rtl/audio_record_ctrl_if.sv
// ----------------------------------------------------------------------------
// audio_record_ctrl_if
// Write port of the shared audio memory.
//   we     1-cycle write strobe
//   addr   packet address
//   wdata  packet data
// Modports: master (capture controller drives), slave (memory receives).
// ----------------------------------------------------------------------------
interface audio_record_ctrl_if #(
    parameter int ADDR_W = audio_record_ctrl_pkg::AUD_ADDR_W,
    parameter int WORD_W = audio_record_ctrl_pkg::AUD_WORD_W
);

    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;

    modport master (output we, output addr, output wdata);
    modport slave  (input  we, input  addr, input  wdata);

endinterface

// File: rtl/audio_record_ctrl_pdm_clk_gen.sv
// ----------------------------------------------------------------------------
// pdm_clk_gen
// Free-running PDM microphone clock divider.
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high
//   mic_clk_o  out  micClk, period 2*CLK_DIV clk cycles, 0 after reset
//   tick_o     out  high in the clk cycle whose closing edge raises micClk
// ----------------------------------------------------------------------------
module pdm_clk_gen
    import audio_record_ctrl_pkg::*;
#(
    parameter int CLK_DIV = AUD_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic mic_clk_o,
    output logic tick_o
);

    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             mic_clk_q, mic_clk_d;
    logic             div_wrap;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can
        // leave it unassigned and infer a latch.
        div_wrap  = (div_cnt_q == DIV_LAST);
        div_cnt_d = div_cnt_q + DIV_W'(1);
        mic_clk_d = mic_clk_q;
        if (div_wrap) begin
            div_cnt_d = '0;
            mic_clk_d = ~mic_clk_q;
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values,
    // independent of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
            mic_clk_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            mic_clk_q <= mic_clk_d;
        end
    end

    assign mic_clk_o = mic_clk_q;
    // Rising micClk edge is the moment the microphone's previous bit is
    // safely settled on micData.
    assign tick_o    = div_wrap & ~mic_clk_q;

endmodule

// File: rtl/audio_record_ctrl.sv
// ----------------------------------------------------------------------------
// audio_record_ctrl
// Capture side of the audio path: drives the PDM mic clock, deserializes the
// 1-bit PDM stream MSB-first into WORD_W-bit packets and writes them to
// audio memory addresses 0..MEM_DEPTH-1. The first word after start is
// discarded while the microphone settles.
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous, active-high
//   recordBtnEN_i  in   1-cycle start pulse (ignored outside IDLE)
//   stopBtnEN_i    in   1-cycle abort pulse (wins over a completing word)
//   micData_i      in   PDM data, asynchronous to clk
//   micClk_o       out  PDM clock, free-running
//   micLRSel_o     out  tied 0 (left channel)
//   recording_o    out  high in PREREC and RECORD
//   done_o         out  1-cycle pulse after the packet at MEM_DEPTH-1 is written
//   mem_if         master modport of the memory write port
// Build option:
//   AUD_REC_CIRCULAR_EN  defined: RECORD wraps the address to 0 after the
//                        last packet and keeps capturing, pulsing done_o on
//                        every wrap; only stop or reset ends capture.
// ----------------------------------------------------------------------------
module audio_record_ctrl
    import audio_record_ctrl_pkg::*;
#(
    parameter int CLK_DIV   = AUD_CLK_DIV,
    parameter int WORD_W    = AUD_WORD_W,
    parameter int ADDR_W    = AUD_ADDR_W,
    parameter int MEM_DEPTH = AUD_MEM_DEPTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                recordBtnEN_i,
    input  logic                stopBtnEN_i,
    input  logic                micData_i,
    output logic                micClk_o,
    output logic                micLRSel_o,
    output logic                recording_o,
    output logic                done_o,
    audio_record_ctrl_if.master mem_if
);

    localparam int               BIT_W     = $clog2(WORD_W);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MEM_DEPTH - 1);

    rec_state_e        state_q, state_d;
    logic              tick;
    logic              mic_meta_q, mic_sync_q;
    // Only the WORD_W-1 most recent samples are kept; the completing sample is
    // appended combinationally when the word is handed to the write stage.
    logic [WORD_W-2:0] hist_q, hist_d;
    logic [WORD_W-1:0] word_next;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              we_q, we_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              capturing, word_done, last_write;
`ifdef AUD_REC_CIRCULAR_EN
    logic              wrap_q, wrap_d;
`endif

    pdm_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk       (clk),
        .reset     (reset),
        .mic_clk_o (micClk_o),
        .tick_o    (tick)
    );

    assign capturing  = (state_q == REC_PREREC) || (state_q == REC_RECORD);
    assign word_done  = tick && capturing && (bit_cnt_q == BIT_LAST);
    assign last_write = we_q && (addr_q == ADDR_LAST);
    assign word_next  = {hist_q, mic_sync_q};

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            REC_IDLE:   if (recordBtnEN_i && !stopBtnEN_i) state_d = REC_PREREC;
            REC_PREREC: if (stopBtnEN_i)                   state_d = REC_IDLE;
                        else if (word_done)                state_d = REC_RECORD;
            REC_RECORD: if (stopBtnEN_i)                   state_d = REC_IDLE;
`ifndef AUD_REC_CIRCULAR_EN
                        else if (last_write)               state_d = REC_DONE;
`endif
            REC_DONE:                                      state_d = REC_IDLE;
            default:                                       state_d = REC_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        recording_o = capturing;
`ifdef AUD_REC_CIRCULAR_EN
        done_o      = wrap_q;
`else
        done_o      = (state_q == REC_DONE);
`endif
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        hist_d    = tick ? word_next[WORD_W-2:0] : hist_q;

        bit_cnt_d = bit_cnt_q;
        if (state_q == REC_IDLE && state_d == REC_PREREC)
            bit_cnt_d = '0;
        else if (tick && capturing)
            bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);

        // Stop in the completing cycle drops the word.
        we_d    = (state_q == REC_RECORD) && word_done && !stopBtnEN_i;
        wdata_d = we_d ? word_next : wdata_q;

        // Address advances in the cycle after the strobe.
        addr_d = addr_q;
        if (state_q == REC_IDLE)
            addr_d = '0;
        else if (we_q && state_q == REC_RECORD) begin
            if (addr_q != ADDR_LAST)
                addr_d = addr_q + ADDR_W'(1);
`ifdef AUD_REC_CIRCULAR_EN
            else
                addr_d = '0;
`endif
        end

`ifdef AUD_REC_CIRCULAR_EN
        wrap_d = last_write && (state_q == REC_RECORD) && !stopBtnEN_i;
`endif
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= REC_IDLE;
            mic_meta_q <= 1'b0;
            mic_sync_q <= 1'b0;
            hist_q     <= '0;
            bit_cnt_q  <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            addr_q     <= '0;
`ifdef AUD_REC_CIRCULAR_EN
            wrap_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mic_meta_q <= micData_i;     // two-flop synchronizer
            mic_sync_q <= mic_meta_q;
            hist_q     <= hist_d;
            bit_cnt_q  <= bit_cnt_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            addr_q     <= addr_d;
`ifdef AUD_REC_CIRCULAR_EN
            wrap_q     <= wrap_d;
`endif
        end
    end

    assign micLRSel_o   = 1'b0;
    assign mem_if.we    = we_q;
    assign mem_if.addr  = addr_q;
    assign mem_if.wdata = wdata_q;

endmodule

// File: tb/tb_audio_record_ctrl.sv
// ----------------------------------------------------------------------------
// tb_audio_record_ctrl
// Self-checking bench for audio_record_ctrl with CLK_DIV=2, WORD_W=8,
// MEM_DEPTH=4. A vector table drives whole recordings (pattern, stop point,
// record re-pulse) with hand-computed write/done counts; hand-written
// sequences cover reset state, record+stop in IDLE and reset mid-word.
// micData is updated on each micClk rising edge, like the real microphone.
// ----------------------------------------------------------------------------
module tb_audio_record_ctrl;

    localparam int CLK_DIV = 2;
    localparam int WW      = 8;
    localparam int AW      = 4;
    localparam int DEPTH   = 4;
    localparam int MAXW    = 64;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef struct {
        logic [7:0] pat;
        int         stop_after;   // 0: run to natural end
        bit         rerec;        // re-pulse record after the first write
        int         exp_writes;
        int         exp_dones;
    } vec_t;

    logic clk = 1'b0;
    logic reset, recordBtnEN_i, stopBtnEN_i, micData_i;
    logic micClk_o, micLRSel_o, recording_o, done_o;

    audio_record_ctrl_if #(.ADDR_W(AW), .WORD_W(WW)) mem_if ();

    audio_record_ctrl #(
        .CLK_DIV(CLK_DIV), .WORD_W(WW), .ADDR_W(AW), .MEM_DEPTH(DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .recordBtnEN_i (recordBtnEN_i),
        .stopBtnEN_i   (stopBtnEN_i),
        .micData_i     (micData_i),
        .micClk_o      (micClk_o),
        .micLRSel_o    (micLRSel_o),
        .recording_o   (recording_o),
        .done_o        (done_o),
        .mem_if        (mem_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // observation state
    int          cyc = 0;
    int          last_rise = 0;
    bit          rise_valid = 1'b0;
    bit          rose_now = 1'b0;
    logic        prev_mic = 1'b0;
    logic        prev_we = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    int          nw = 0;
    int          nd = 0;
    logic [AW-1:0] wr_addr [MAXW];
    logic [WW-1:0] wr_data [MAXW];

    // microphone model
    logic [7:0] pat = 8'hA5;
    int         drv_idx = 7;
    int         last_idx = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_micclk",    micClk_o,     0);
        check("rst_lrsel",     micLRSel_o,   0);
        check("rst_we",        mem_if.we,    0);
        check("rst_addr",      mem_if.addr,  0);
        check("rst_wdata",     mem_if.wdata, 0);
        check("rst_recording", recording_o,  0);
        check("rst_done",      done_o,       0);
    endtask

    // One clock cycle: sample on the falling edge and run the inline checks.
    task automatic tick_cycle();
        @(negedge clk);
        cyc++;
        rose_now = micClk_o && !prev_mic;
        if (rose_now) begin
            if (rise_valid) check("micclk_period", cyc - last_rise, 2 * CLK_DIV);
            last_rise  = cyc;
            rise_valid = 1'b1;
        end
        if (mem_if.we) begin
            check("we_not_back_to_back", prev_we, 0);
            check("we_one_after_tick", {prev_mic, micClk_o}, 2'b01);
            check("lrsel_zero", micLRSel_o, 0);
            if (nw < MAXW) begin
                wr_addr[nw] = mem_if.addr;
                wr_data[nw] = mem_if.wdata;
            end
            nw++;
        end
        if (done_o) begin
            check("done_after_last_write", {prev_we, prev_addr}, {1'b1, LAST});
            nd++;
        end
        prev_we   = mem_if.we;
        prev_addr = mem_if.addr;
        prev_mic  = micClk_o;
    endtask

    // Pulse record so the first PREREC tick samples pattern bit 7.
    task automatic start_record();
        bit ok = 1'b0;
        for (int c = 0; c < 24 * CLK_DIV; c++) begin
            tick_cycle();
            if (rose_now && last_idx == 7) begin
                ok = 1'b1;
                break;
            end
        end
        check("align_found", ok, 1);
        recordBtnEN_i = 1'b1;
        tick_cycle();
        recordBtnEN_i = 1'b0;
        check("recording_on", recording_o, 1);
    endtask

    task automatic run_case(input int idx, input vec_t v);
        int nw0 = nw;
        int nd0 = nd;
        bit stop_sent = 1'b0;
        bit rerec_sent = 1'b0;
        pat = v.pat;
        start_record();
        for (int c = 0; c < 600; c++) begin
            tick_cycle();
            if (!recording_o) break;
            if (v.stop_after != 0 && !stop_sent && nw - nw0 == v.stop_after) begin
                stopBtnEN_i = 1'b1;
                tick_cycle();
                stopBtnEN_i = 1'b0;
                stop_sent = 1'b1;
                check("rec_off_after_stop", recording_o, 0);
                break;
            end
            if (v.rerec && !rerec_sent && nw - nw0 == 1) begin
                recordBtnEN_i = 1'b1;
                tick_cycle();
                recordBtnEN_i = 1'b0;
                rerec_sent = 1'b1;
            end
        end
        check("capture_ended", recording_o, 0);
        repeat (80) tick_cycle();
        check("idle_after", recording_o, 0);
        check($sformatf("v%0d_writes", idx), nw - nw0, v.exp_writes);
        check($sformatf("v%0d_dones", idx), nd - nd0, v.exp_dones);
        for (int i = 0; i < v.exp_writes && nw0 + i < MAXW; i++) begin
            check($sformatf("v%0d_addr%0d", idx, i), wr_addr[nw0 + i], i % DEPTH);
            check($sformatf("v%0d_data%0d", idx, i), wr_data[nw0 + i], v.pat);
        end
    endtask

    // Microphone: new bit after every micClk rising edge, MSB first.
    initial begin
        micData_i = 1'b0;
        forever begin
            @(posedge micClk_o);
            micData_i = pat[drv_idx];
            last_idx  = drv_idx;
            drv_idx   = (drv_idx == 0) ? 7 : drv_idx - 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int   nv;
        int   nbase;
`ifdef AUD_REC_CIRCULAR_EN
        vecs[0] = '{8'hA5, 9, 1'b0, 9, 2};   // addrs 0,1,2,3,0,1,2,3,0
        vecs[1] = '{8'h3C, 2, 1'b0, 2, 0};
        vecs[2] = '{8'h81, 3, 1'b1, 3, 0};
        nv = 3;
`else
        vecs[0] = '{8'hA5, 0, 1'b0, 4, 1};   // full single-shot recording
        vecs[1] = '{8'hA5, 2, 1'b0, 2, 0};   // stop after the 2nd write
        vecs[2] = '{8'h3C, 0, 1'b1, 4, 1};   // record re-pulse ignored
        vecs[3] = '{8'h81, 0, 1'b0, 4, 1};
        nv = 4;
`endif

        reset = 1'b0;
        recordBtnEN_i = 1'b0;
        stopBtnEN_i = 1'b0;
        #2 reset = 1'b1;
        #1 check_reset_outputs();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // IDLE: micClk free-runs with its nominal period
        repeat (20) tick_cycle();
        check("idle_not_recording", recording_o, 0);

        for (int k = 0; k < nv; k++) run_case(k, vecs[k]);

        // record and stop together in IDLE: stay IDLE
        nbase = nw;
        recordBtnEN_i = 1'b1;
        stopBtnEN_i = 1'b1;
        tick_cycle();
        recordBtnEN_i = 1'b0;
        stopBtnEN_i = 1'b0;
        check("rec_stop_same_cycle", recording_o, 0);
        repeat (40) tick_cycle();
        check("rec_stop_no_writes", nw - nbase, 0);

        // async reset in the middle of the second word
        pat = 8'hA5;
        nbase = nw;
        start_record();
        for (int c = 0; c < 200 && nw - nbase < 1; c++) tick_cycle();
        check("mid_first_write", nw - nbase, 1);
        repeat (10) tick_cycle();
        check("mid_still_recording", recording_o, 1);
        reset = 1'b1;
        #1 check_reset_outputs();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        prev_mic = 1'b0;
        prev_we = 1'b0;
        rise_valid = 1'b0;
        nbase = nw;
        repeat (100) tick_cycle();
        check("no_write_after_reset", nw - nbase, 0);
        check("idle_after_reset", recording_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
